step_tick_sequencer: RTL and testbench
======================================

// Module: step_tick_sequencer
// PURPOSE
// Upstream control stage for the 8-LED pattern state machine.
// - Conditions the raw board inputs for pause, single-step and direction.
// - Emits a one-cycle step_en pulse at a switch-selectable rate, or on demand while paused.
// - The pattern FSM advances only on step_en and samples dir in the same cycle.
// - Replaces the free-running divided clock with a clock enable on the 10 MHz domain.
// PARAMETERS
// BASE_PERIOD      10_000_000  cycles between steps at rate_sel=0 (1 Hz @ 10 MHz); >= 16
// DEBOUNCE_CYCLES  200_000     consecutive stable cycles to accept an input change (20 ms); >= 2
// PORTS
// clk        in   1  10 MHz system clock
// reset      in   1  asynchronous, active-high reset
// pb_pause   in   1  raw push button, 1 = pressed; each press toggles RUN/PAUSE
// pb_step    in   1  raw push button, 1 = pressed; each press gives one step while paused
// dir_sw     in   1  raw switch: 0 = forward, 1 = reverse
// rate_sel   in   2  step period = BASE_PERIOD >> rate_sel (1/2/4/8 Hz)
// step_en    out  1  registered, one-cycle advance pulse
// dir        out  1  registered, debounced dir_sw
// running    out  1  1 = RUN, 0 = PAUSE
// BEHAVIOUR
// Reset values: step_en=0, dir=0, running=1 (RUN). Prescaler, debounce counters and stable values are all 0.
// Input conditioning (pb_pause, pb_step, dir_sw), per input:
// - 2-FF synchronizer feeds a debounce counter.
// - The counter clears whenever the sync output equals the stable value.
// - The counter increments while they differ.
// - The stable value flips on the edge where the count reaches DEBOUNCE_CYCLES.
// - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable value.
// - Raw change held steady -> stable change after exactly 2+DEBOUNCE_CYCLES edges.
// Press event: rising edge of stable pb (stable & ~stable_q). Releases are ignored.
// dir is the stable dir_sw value. It is never gated by step_en.
// Prescaler cnt is 24 bits. period = BASE_PERIOD >> rate_sel, shift computed combinationally each cycle.
// FSM with states RUN and PAUSE:
// - RUN: cnt >= period-1 -> step_en=1 next cycle and cnt<=0; else cnt<=cnt+1.
//   A pause press -> PAUSE and cnt<=0.
// - PAUSE: cnt is held at 0 and there are no timed steps.
//   A step press -> step_en=1 for one cycle.
//   A pause press -> RUN with cnt=0, so the first timed step comes a full period later.
// Latency: pb_step raw rise -> step_en high after exactly DEBOUNCE_CYCLES+3 edges.
// Simultaneous events:
// - RUN, terminal count and pause press in the same cycle: step_en still pulses, then PAUSE.
// - PAUSE, step press and pause press in the same cycle: pause wins, no step pulse, -> RUN.
// - rate_sel lowered while cnt >= new period-1: immediate step and wrap on the next edge (>= compare).
// - Step press while in RUN: ignored.
// step_en is never high on two consecutive cycles.
// Reset mid-operation: all state returns to reset values immediately. A held button must be released and pressed again to act.
// STRUCTURE
// Package led_lab_pkg: run_state_t enum {RUN, PAUSE}; RATE_* shift constants; CNT_W = 24.
// Sub-module input_debouncer (#DEBOUNCE_CYCLES; clk, reset, raw -> stable), instantiated 3x.
// Top level holds: edge detectors, prescaler, FSM, output registers.
// TESTING (bench: BASE_PERIOD=16, DEBOUNCE_CYCLES=4)
// 1 Reset, RUN, rate_sel=0 -> step_en pulses every 16 cycles, first pulse on cycle 16 after reset release; running=1.
// 2 rate_sel=3 -> period 2, step_en high every 2nd cycle; switch to 0 at cnt=1 -> next pulse 15 cycles later.
// 3 pb_pause glitch of 3 cycles -> no state change; hold 10 cycles -> running=0 at edge 7; no further step_en.
// 4 In PAUSE, pb_step held 10 cycles -> exactly one step_en, at edge 7; repeat press -> second pulse.
// 5 In PAUSE, pb_step and pb_pause rise together -> running=1, no step_en; next step 16 cycles after the RUN entry.
// 6 dir_sw toggled for 2 cycles -> dir unchanged; held -> dir flips at edge 6; reset mid-count -> step_en=0, dir=0, running=1.

Source files
------------

// File: rtl/led_lab_pkg.sv
// Shared types and constants for the LED-lab step/tick control path.
// Rate shift constants map rate_sel onto a divided step period.
package led_lab_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } run_state_t;

    localparam int CNT_W = 24;

    localparam logic [1:0] RATE_1HZ = 2'd0;
    localparam logic [1:0] RATE_2HZ = 2'd1;
    localparam logic [1:0] RATE_4HZ = 2'd2;
    localparam logic [1:0] RATE_8HZ = 2'd3;

    // Step period in clock cycles for a given base period and rate selection.
    function automatic logic [CNT_W-1:0] step_period(input logic [CNT_W-1:0] base,
                                                     input logic [1:0]       rate);
        logic [CNT_W-1:0] p;
        p = base;
        case (rate)
            RATE_1HZ: p = base;
            RATE_2HZ: p = base >> 1;
            RATE_4HZ: p = base >> 2;
            RATE_8HZ: p = base >> 3;
            default:  p = base;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability counter: the stable output
// only follows the input after DEBOUNCE_CYCLES consecutive differing cycles.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic          stable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            // Any cycle of agreement restarts the count, so glitches are dropped.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                cnt_q    <= '0;
                stable_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/step_tick_sequencer.sv
// Upstream control for the LED pattern FSM: conditions the board inputs and
// produces a one-cycle step_en clock enable at a selectable rate or on demand.
module step_tick_sequencer
    import led_lab_pkg::*;
#(
    parameter int BASE_PERIOD     = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pb_pause,
    input  logic       pb_step,
    input  logic       dir_sw,
    input  logic [1:0] rate_sel,
    output logic       step_en,
    output logic       dir,
    output logic       running
);

    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_PERIOD);
    localparam int SW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [SW-1:0] SETTLE = SW'(DEBOUNCE_CYCLES + 2);

    logic pause_stable;
    logic step_stable;
    logic dir_stable;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk    (clk),
        .reset  (reset),
        .raw    (pb_pause),
        .stable (pause_stable)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk    (clk),
        .reset  (reset),
        .raw    (pb_step),
        .stable (step_stable)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
        .clk    (clk),
        .reset  (reset),
        .raw    (dir_sw),
        .stable (dir_stable)
    );

    // A button already held at reset reaches its stable value only after the
    // debouncer settles; arming waits for a released level so it cannot act.
    logic [SW-1:0] settle_q;
    logic          pause_armed_q;
    logic          step_armed_q;
    logic          pause_prev_q;
    logic          step_prev_q;
    logic          settled;

    assign settled = (settle_q == SETTLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_q      <= '0;
            pause_armed_q <= 1'b0;
            step_armed_q  <= 1'b0;
            pause_prev_q  <= 1'b0;
            step_prev_q   <= 1'b0;
        end else begin
            if (!settled) begin
                settle_q <= settle_q + SW'(1);
            end
            if (settled && !pause_stable) begin
                pause_armed_q <= 1'b1;
            end
            if (settled && !step_stable) begin
                step_armed_q <= 1'b1;
            end
            pause_prev_q <= pause_stable;
            step_prev_q  <= step_stable;
        end
    end

    logic pause_press;
    logic step_press;

    assign pause_press = pause_armed_q & pause_stable & ~pause_prev_q;
    assign step_press  = step_armed_q & step_stable & ~step_prev_q;

    logic [CNT_W-1:0] period_m1;

    assign period_m1 = step_period(BASE, rate_sel) - CNT_W'(1);

    run_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             step_en_q;
    logic             running_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            step_en_q <= 1'b0;
            running_q <= 1'b1;
        end else begin
            step_en_q <= 1'b0;
            case (state_q)
                RUN: begin
                    // >= so that lowering the period past cnt steps at once.
                    if (cnt_q >= period_m1) begin
                        step_en_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (pause_press) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                PAUSE: begin
                    cnt_q <= '0;
                    if (pause_press) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (step_press && !step_en_q) begin
                        step_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign step_en = step_en_q;
    assign running = running_q;
    assign dir     = dir_stable;

endmodule

// File: tb/tb_step_tick_sequencer.sv
// Directed bench for step_tick_sequencer with a 16-cycle base period and
// 4-cycle debounce, each scenario checked against hand-computed edge counts.
module tb_step_tick_sequencer;

    logic       clk;
    logic       reset;
    logic       pb_pause;
    logic       pb_step;
    logic       dir_sw;
    logic [1:0] rate_sel;
    logic       step_en;
    logic       dir;
    logic       running;

    int errors;
    int checks;

    step_tick_sequencer #(
        .BASE_PERIOD     (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pb_pause (pb_pause),
        .pb_step  (pb_step),
        .dir_sw   (dir_sw),
        .rate_sel (rate_sel),
        .step_en  (step_en),
        .dir      (dir),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        pb_pause = 1'b0;
        pb_step  = 1'b0;
        dir_sw   = 1'b0;
        rate_sel = 2'd0;
        tick();
        tick();
        checks++;
        if (step_en !== 1'b0) begin errors++; $display("FAIL reset_step_en got=%b exp=0", step_en); end
        checks++;
        if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", dir); end
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL reset_running got=%b exp=1", running); end
        reset = 1'b0;
    endtask

    // First pulse on edge 16 after release, then every 16 edges.
    task automatic test_base_rate();
        for (int k = 1; k <= 32; k++) begin
            logic exp_v;
            tick();
            exp_v = (k % 16 == 0);
            checks++;
            if (step_en !== exp_v) begin
                errors++;
                $display("FAIL base_rate edge=%0d got=%b exp=%b", k, step_en, exp_v);
            end
        end
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL base_running got=%b exp=1", running); end
    endtask

    task automatic test_rate_change();
        rate_sel = 2'd3;
        for (int k = 1; k <= 8; k++) begin
            logic exp_v;
            tick();
            exp_v = (k % 2 == 0);
            checks++;
            if (step_en !== exp_v) begin
                errors++;
                $display("FAIL rate8 edge=%0d got=%b exp=%b", k, step_en, exp_v);
            end
        end
        tick();
        rate_sel = 2'd0;
        for (int k = 1; k <= 15; k++) begin
            logic exp_v;
            tick();
            exp_v = (k == 15);
            checks++;
            if (step_en !== exp_v) begin
                errors++;
                $display("FAIL rate_down edge=%0d got=%b exp=%b", k, step_en, exp_v);
            end
        end
        // cnt is 5 after these edges; period 4 makes the very next edge terminal.
        for (int k = 0; k < 5; k++) tick();
        rate_sel = 2'd2;
        for (int k = 1; k <= 5; k++) begin
            logic exp_v;
            tick();
            exp_v = (k == 1) || (k == 5);
            checks++;
            if (step_en !== exp_v) begin
                errors++;
                $display("FAIL rate_lowered edge=%0d got=%b exp=%b", k, step_en, exp_v);
            end
        end
        rate_sel = 2'd0;
    endtask

    task automatic test_pause_debounce();
        pb_pause = 1'b1;
        tick();
        tick();
        tick();
        pb_pause = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (running !== 1'b1) begin
                errors++;
                $display("FAIL pause_glitch edge=%0d got=%b exp=1", k, running);
            end
        end
        pb_pause = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) begin
                checks++;
                if (running !== 1'b1) begin errors++; $display("FAIL pause_early got=%b exp=1", running); end
            end
            if (k == 7) begin
                checks++;
                if (running !== 1'b0) begin errors++; $display("FAIL pause_enter got=%b exp=0", running); end
            end
        end
        pb_pause = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            checks++;
            if (step_en !== 1'b0 || running !== 1'b0) begin
                errors++;
                $display("FAIL paused_idle edge=%0d step_en=%b running=%b exp=0/0", k, step_en, running);
            end
        end
    endtask

    task automatic test_single_step();
        for (int rep = 0; rep < 2; rep++) begin
            pb_step = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                logic exp_v;
                tick();
                exp_v = (k == 7);
                checks++;
                if (step_en !== exp_v) begin
                    errors++;
                    $display("FAIL single_step rep=%0d edge=%0d got=%b exp=%b", rep, k, step_en, exp_v);
                end
            end
            pb_step = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                tick();
                checks++;
                if (step_en !== 1'b0) begin
                    errors++;
                    $display("FAIL step_release rep=%0d edge=%0d got=%b exp=0", rep, k, step_en);
                end
            end
        end
    endtask

    // Pause press wins over a coincident step press; RUN restarts a full period.
    task automatic test_back_to_back();
        pb_step  = 1'b1;
        pb_pause = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            logic exp_v;
            tick();
            if (k == 10) begin
                pb_step  = 1'b0;
                pb_pause = 1'b0;
            end
            exp_v = (k == 23);
            checks++;
            if (step_en !== exp_v) begin
                errors++;
                $display("FAIL both_press edge=%0d got=%b exp=%b", k, step_en, exp_v);
            end
            if (k == 6 || k == 7) begin
                checks++;
                if (running !== (k == 7)) begin
                    errors++;
                    $display("FAIL both_running edge=%0d got=%b exp=%b", k, running, (k == 7));
                end
            end
        end
    endtask

    task automatic test_dir_and_reset();
        dir_sw = 1'b1;
        tick();
        tick();
        dir_sw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (dir !== 1'b0) begin errors++; $display("FAIL dir_glitch edge=%0d got=%b exp=0", k, dir); end
        end
        dir_sw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            logic exp_v;
            tick();
            exp_v = (k >= 6);
            checks++;
            if (dir !== exp_v) begin
                errors++;
                $display("FAIL dir_flip edge=%0d got=%b exp=%b", k, dir, exp_v);
            end
        end
        pb_pause = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        pb_pause = 1'b0;
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL pre_reset_pause got=%b exp=0", running); end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (step_en !== 1'b0) begin errors++; $display("FAIL midreset_step_en got=%b exp=0", step_en); end
        checks++;
        if (dir !== 1'b0) begin errors++; $display("FAIL midreset_dir got=%b exp=0", dir); end
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL midreset_running got=%b exp=1", running); end
        dir_sw = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_held_through_reset();
        pb_pause = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (running !== 1'b1) begin
                errors++;
                $display("FAIL held_reset edge=%0d got=%b exp=1", k, running);
            end
        end
        pb_pause = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        pb_pause = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k >= 6) begin
                checks++;
                if (running !== (k == 6)) begin
                    errors++;
                    $display("FAIL repress edge=%0d got=%b exp=%b", k, running, (k == 6));
                end
            end
        end
        pb_pause = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_base_rate();
        test_rate_change();
        test_pause_debounce();
        test_single_step();
        test_back_to_back();
        test_dir_and_reset();
        test_held_through_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
